// File: rtl/qspi_req_arbiter.sv
// Arbitrates XIP and indirect requests into the QSPI sequencing FSM start/busy handshake.
// Define BREAK_ON_IND_EN to let a pending indirect request abort an active XIP burst.
module qspi_req_arbiter #(
    parameter int unsigned STARVE_LIM = 4,
    parameter int unsigned START_TO   = 16
) (
    input  logic       hclk,
    input  logic       h_rst,
    input  logic       xip_req_in,
    input  logic       ind_req_in,
    input  logic       qspi_busy_in,
    output logic       xip_ack_out,
    output logic       ind_ack_out,
    output logic       xip_done_out,
    output logic       ind_done_out,
    output logic       start_new_xip_seq_out,
    output logic       start_indrct_mode_out,
    output logic       break_seq_out,
    output logic       start_err_out,
    output logic [1:0] grant_owner_out
);
    localparam int unsigned WinW = $clog2(STARVE_LIM + 1);
    localparam int unsigned ToW  = (START_TO > 1) ? $clog2(START_TO) : 1;
    localparam logic [WinW-1:0] WinLim = WinW'(STARVE_LIM);
    localparam logic [ToW-1:0]  ToLast = ToW'(START_TO - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitXip,
        StXipAct,
        StWaitInd,
        StIndAct
    } state_e;

    state_e          r_state;
    logic [WinW-1:0] r_win_cnt;
    logic [ToW-1:0]  r_to_cnt;
    logic            r_xip_ack;
    logic            r_ind_ack;
    logic            r_xip_done;
    logic            r_ind_done;
    logic            r_start_xip;
    logic            r_start_ind;
    logic            r_start_err;
    logic [1:0]      r_grant;
    logic            w_pick_ind;

`ifdef BREAK_ON_IND_EN
    logic r_brk;
    logic r_brk_pend;

    // An XIP burst broken for an indirect request hands the next grant to indirect.
    assign w_pick_ind = ind_req_in && (!xip_req_in || (r_win_cnt == WinLim) || r_brk_pend);
    assign break_seq_out = r_brk;
`else
    assign w_pick_ind = ind_req_in && (!xip_req_in || (r_win_cnt == WinLim));
    assign break_seq_out = 1'b0;
`endif

    always_ff @(posedge hclk) begin
        if (h_rst) begin
            r_state     <= StIdle;
            r_win_cnt   <= '0;
            r_to_cnt    <= '0;
            r_xip_ack   <= 1'b0;
            r_ind_ack   <= 1'b0;
            r_xip_done  <= 1'b0;
            r_ind_done  <= 1'b0;
            r_start_xip <= 1'b0;
            r_start_ind <= 1'b0;
            r_start_err <= 1'b0;
            r_grant     <= 2'b00;
`ifdef BREAK_ON_IND_EN
            r_brk       <= 1'b0;
            r_brk_pend  <= 1'b0;
`endif
        end else begin
            r_xip_ack   <= 1'b0;
            r_ind_ack   <= 1'b0;
            r_xip_done  <= 1'b0;
            r_ind_done  <= 1'b0;
            r_start_err <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (!qspi_busy_in && (xip_req_in || ind_req_in)) begin
                        r_to_cnt <= '0;
`ifdef BREAK_ON_IND_EN
                        r_brk_pend <= 1'b0;
`endif
                        if (w_pick_ind) begin
                            r_state     <= StWaitInd;
                            r_start_ind <= 1'b1;
                            r_grant     <= 2'b10;
                            r_win_cnt   <= '0;
                        end else begin
                            r_state     <= StWaitXip;
                            r_start_xip <= 1'b1;
                            r_grant     <= 2'b01;
                            if (ind_req_in && (r_win_cnt != WinLim)) begin
                                r_win_cnt <= r_win_cnt + 1'b1;
                            end
                        end
                    end
                end
                StWaitXip: begin
                    // Busy is checked first so it beats a coincident timeout.
                    if (qspi_busy_in) begin
                        r_state     <= StXipAct;
                        r_start_xip <= 1'b0;
                        r_xip_ack   <= 1'b1;
                        r_to_cnt    <= '0;
                    end else if (r_to_cnt == ToLast) begin
                        r_state     <= StIdle;
                        r_start_xip <= 1'b0;
                        r_start_err <= 1'b1;
                        r_grant     <= 2'b00;
                        r_to_cnt    <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                StXipAct: begin
                    if (!qspi_busy_in) begin
                        r_state    <= StIdle;
                        r_xip_done <= 1'b1;
                        r_grant    <= 2'b00;
`ifdef BREAK_ON_IND_EN
                        r_brk      <= 1'b0;
`endif
                    end
`ifdef BREAK_ON_IND_EN
                    else if (ind_req_in) begin
                        r_brk      <= 1'b1;
                        r_brk_pend <= 1'b1;
                    end
`endif
                end
                StWaitInd: begin
                    if (qspi_busy_in) begin
                        r_state     <= StIndAct;
                        r_start_ind <= 1'b0;
                        r_ind_ack   <= 1'b1;
                        r_to_cnt    <= '0;
                    end else if (r_to_cnt == ToLast) begin
                        r_state     <= StIdle;
                        r_start_ind <= 1'b0;
                        r_start_err <= 1'b1;
                        r_grant     <= 2'b00;
                        r_to_cnt    <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                StIndAct: begin
                    if (!qspi_busy_in) begin
                        r_state    <= StIdle;
                        r_ind_done <= 1'b1;
                        r_grant    <= 2'b00;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign xip_ack_out           = r_xip_ack;
    assign ind_ack_out           = r_ind_ack;
    assign xip_done_out          = r_xip_done;
    assign ind_done_out          = r_ind_done;
    assign start_new_xip_seq_out = r_start_xip;
    assign start_indrct_mode_out = r_start_ind;
    assign start_err_out         = r_start_err;
    assign grant_owner_out       = r_grant;
endmodule

// File: doc/qspi_req_arbiter.md
Name: qspi_req_arbiter

Overview:
Sits between the AHB-side request sources and the QSPI sequencing FSM. Arbitrates between XIP read requests from the AHB slave controller and indirect-mode requests from the register block. Drives the start_new_xip_seq / start_indrct_mode_in level handshake into the QSPI FSM and tracks its busy flag to completion. Provides starvation protection for indirect requests and a start-timeout error.

Parameters:
STARVE_LIM, 4, consecutive contested XIP grants after which a pending indirect request wins arbitration.
START_TO, 16, hclk cycles allowed between start assertion and qspi_busy_in going high.

Ports:
hclk  in  1  system clock
h_rst  in  1  synchronous, active-high reset
xip_req_in  in  1  XIP sequence request (level)
ind_req_in  in  1  indirect-mode request (level)
qspi_busy_in  in  1  QSPI FSM busy flag, already synchronised to hclk
xip_ack_out  out  1  1-cycle pulse: XIP sequence accepted by QSPI FSM
ind_ack_out  out  1  1-cycle pulse: indirect sequence accepted
xip_done_out  out  1  1-cycle pulse: XIP sequence finished
ind_done_out  out  1  1-cycle pulse: indirect sequence finished
start_new_xip_seq_out  out  1  level start to QSPI FSM (XIP)
start_indrct_mode_out  out  1  level start to QSPI FSM (indirect)
break_seq_out  out  1  abort the current XIP burst (see Optional Feature)
start_err_out  out  1  1-cycle pulse: start timeout
grant_owner_out  out  2  00 none, 01 XIP, 10 indirect

Behaviour:
- One clock: hclk. Reset is synchronous and active-high on h_rst.
- Reset, including mid-operation: state IDLE, all outputs 0, grant_owner 00, timeout counter 0, win counter 0. A start held at reset time drops in the same cycle.
- States: IDLE, WAIT_XIP, XIP_ACT, WAIT_IND, IND_ACT.
- IDLE:
  - Grants only when qspi_busy_in=0.
  - xip_req only -> WAIT_XIP. ind_req only -> WAIT_IND.
  - Both requests: WAIT_IND if win_cnt==STARVE_LIM, else WAIT_XIP.
- win_cnt, width $clog2(STARVE_LIM+1):
  - Increments, saturating at STARVE_LIM, on an XIP grant while ind_req_in=1.
  - Clears on every indirect grant.
- WAIT_x:
  - Matching start output=1; grant_owner set.
  - Timeout counter increments each cycle.
  - qspi_busy_in=1 -> x_ACT, ack pulse for x in the same transition (registered, visible the next cycle), start drops, counter clears.
  - Counter reaches START_TO-1 with busy still 0 -> start_err pulse, start drops, back to IDLE, no ack. The request is re-arbitrated if it is still held.
- x_ACT: start=0, grant_owner held. qspi_busy_in=0 -> done pulse for x, grant_owner 00, IDLE.
- Minimum idle gap: one IDLE cycle between sequences.
- Requesters hold req until ack, then deassert in the cycle after ack. req is sampled only in IDLE; a req held through done starts a new sequence.
- Start outputs are mutually exclusive, never both 1.
- ack and done pulse at most once per sequence.
- Simultaneous busy rise and timeout terminal count: busy wins, ack is given.

Optional Feature:
Macro BREAK_ON_IND_EN.
- Defined: in XIP_ACT, ind_req_in=1 drives break_seq_out=1 (level) until qspi_busy_in falls. xip_done then pulses, and the following IDLE arbitration grants indirect regardless of win_cnt.
- Undefined: break_seq_out tied 0; indirect waits for natural XIP completion.

Test Plan:
- xip_req=1, busy rises 3 cycles after start -> start_new_xip_seq high 3 cycles, xip_ack 1 pulse, grant_owner=01; busy falls -> xip_done pulse, grant_owner=00.
- ind_req and xip_req both held continuously, STARVE_LIM=4 -> grant order X,X,X,X,I,X,X,X,X,I.
- xip_req=1, busy never rises, START_TO=16 -> start high exactly 16 cycles, start_err pulse, no ack, re-grant follows after one IDLE cycle.
- h_rst asserted during IND_ACT -> next cycle all outputs 0; after release with busy=0 and no req, stays IDLE.
- With BREAK_ON_IND_EN, ind_req during XIP_ACT -> break_seq=1 until busy falls, xip_done, then start_indrct_mode=1. Without the macro, break_seq stays 0 throughout.
- busy rise coincident with timeout terminal count -> ack given, start_err stays 0.
